lsq_mem_port_arbiter: RTL

//  Sequences the single data-memory port between retired stores and loads that missed LSQ forwarding.

---
 rtl/lsq_mem_port_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lsq_mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsq_mem_port_arbiter : arbitrates the single data-memory port between an
//                        in-order store buffer and one pending load.
// Revision: 1.0
// ----------------------------------------------------------------------------
module lsq_mem_port_arbiter #(
  parameter int SB_DEPTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_req_valid,
  output logic        st_req_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic        st_byte,
  input  logic        ld_req_valid,
  output logic        ld_req_ready,
  input  logic [31:0] ld_addr,
  input  logic        ld_byte,
  input  logic [5:0]  ld_tag,
  output logic        mem_valid,
  output logic        mem_ls,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_bms,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata,
  output logic        ld_resp_valid,
  output logic [5:0]  ld_resp_tag,
  output logic [31:0] ld_resp_value,
  output logic        sb_empty
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state;
  logic [31:0]   sb_addr [SB_DEPTH];
  logic [31:0]   sb_data [SB_DEPTH];
  logic          sb_byte [SB_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic          slot_valid;
  logic [31:0]   slot_addr;
  logic          slot_byte;
  logic [5:0]    slot_tag;
  logic          cur_load;

  logic          push;
  logic          pop;
  logic          cand_valid;
  logic [31:0]   cand_addr;
  logic          cand_byte;
  logic          hazard;
  logic          sel_load;
  logic          sel_store;

  assign st_req_ready = (count < CW'(SB_DEPTH));
  assign ld_req_ready = ~slot_valid;
  assign sb_empty     = (count == '0);
  assign push         = st_req_valid & st_req_ready;
  assign pop          = (state == WAIT) & mem_done & ~cur_load;

  // A load offered into an empty slot competes for the port in the same cycle.
  assign cand_valid = slot_valid | ld_req_valid;
  assign cand_addr  = slot_valid ? slot_addr : ld_addr;
  assign cand_byte  = slot_valid ? slot_byte : ld_byte;

  always_comb begin
    logic [PW-1:0] off;
    hazard = 1'b0;
    off    = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      off = PW'(i) - head;
      if (({1'b0, off} < count) && (sb_addr[i][31:2] == cand_addr[31:2]))
        hazard = 1'b1;
    end
  end

  assign sel_load  = (state == IDLE) & cand_valid & ~hazard &
                     (sb_empty | (starve_cnt < SW'(STARVE_LIMIT)));
  assign sel_store = (state == IDLE) & ~sel_load & ~sb_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[tail] <= st_addr;
      sb_data[tail] <= st_data;
      sb_byte[tail] <= st_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      starve_cnt    <= '0;
      slot_valid    <= 1'b0;
      slot_addr     <= '0;
      slot_byte     <= 1'b0;
      slot_tag      <= '0;
      cur_load      <= 1'b0;
      mem_valid     <= 1'b0;
      mem_ls        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_bms       <= 1'b0;
      ld_resp_valid <= 1'b0;
      ld_resp_tag   <= '0;
      ld_resp_value <= '0;
    end else begin
      mem_valid     <= 1'b0;
      ld_resp_valid <= 1'b0;

      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (ld_req_valid && ld_req_ready) begin
        slot_valid <= 1'b1;
        slot_addr  <= ld_addr;
        slot_byte  <= ld_byte;
        slot_tag   <= ld_tag;
      end

      case (state)
        IDLE: begin
          if (sel_load) begin
            mem_valid <= 1'b1;
            mem_ls    <= 1'b1;
            mem_addr  <= cand_addr;
            mem_wdata <= '0;
            mem_bms   <= cand_byte;
            cur_load  <= 1'b1;
            state     <= WAIT;
            if (!sb_empty && (starve_cnt != SW'(STARVE_LIMIT)))
              starve_cnt <= starve_cnt + SW'(1);
          end else if (sel_store) begin
            mem_valid  <= 1'b1;
            mem_ls     <= 1'b0;
            mem_addr   <= sb_addr[head];
            mem_wdata  <= sb_data[head];
            mem_bms    <= sb_byte[head];
            cur_load   <= 1'b0;
            state      <= WAIT;
            starve_cnt <= '0;
          end
        end
        WAIT: begin
          if (mem_done) begin
            state <= IDLE;
            if (cur_load) begin
              ld_resp_valid <= 1'b1;
              ld_resp_tag   <= slot_tag;
              ld_resp_value <= mem_rdata;
              slot_valid    <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
